// File: rtl/atm_bank_responder.sv
// atm_bank_responder
// Bank-side responder for the ATM controller. Accepts one request at a time
// over a valid/ready handshake, evaluates it against a small card table
// (balance, failed-PIN count, blocked flag, session-authorised flag) and
// returns a registered response code and balance.
//
// Ports:
//   clock         single clock, all state on posedge
//   reset         synchronous, active-low
//   req_valid     request present
//   req_ready     high only while idle
//   req_op        0 VERIFY, 1 WITHDRAW, 2 BALANCE, 3 UNBLOCK
//   card_id       card table index
//   pin           PIN for VERIFY / UNBLOCK
//   amount        unsigned withdraw amount
//   resp_valid    response present, held until resp_ready
//   resp_ready    initiator consumes response
//   resp_code     0 OK, 1 BAD_PIN, 2 BLOCKED, 3 INSUFFICIENT, 4 NOT_AUTH
//   resp_balance  card balance after the op when OK, else 0
//   card_blocked  live blocked flag per card
//
// States:
//   state     | meaning
//   ST_IDLE   | req_ready high, waiting for a request
//   ST_LOOKUP | addressed card entry copied into working registers
//   ST_EXEC   | op evaluated, card entry written back, response loaded
//   ST_RESP   | resp_valid raised on first edge, dropped on handshake

module atm_bank_responder #(
    parameter int          NUM_CARDS    = 4,
    parameter logic [15:0] PIN_VALID    = 16'd1234,
    parameter logic [15:0] ADMIN_PIN    = 16'hBEEF,
    parameter logic [15:0] BALANCE_INIT = 16'd10000,
    parameter int          MAX_FAILS    = 2,
    localparam int         CARD_W       = (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [CARD_W-1:0]    card_id,
    input  logic [15:0]          pin,
    input  logic [15:0]          amount,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [2:0]           resp_code,
    output logic [15:0]          resp_balance,
    output logic [NUM_CARDS-1:0] card_blocked
);

    localparam int            FW    = $clog2(MAX_FAILS + 1);
    localparam logic [FW-1:0] MAX_F = FW'(MAX_FAILS);

    localparam logic [1:0] OP_VERIFY   = 2'd0;
    localparam logic [1:0] OP_WITHDRAW = 2'd1;
    localparam logic [1:0] OP_BALANCE  = 2'd2;
    localparam logic [1:0] OP_UNBLOCK  = 2'd3;

    localparam logic [2:0] RC_OK           = 3'd0;
    localparam logic [2:0] RC_BAD_PIN      = 3'd1;
    localparam logic [2:0] RC_BLOCKED      = 3'd2;
    localparam logic [2:0] RC_INSUFFICIENT = 3'd3;
    localparam logic [2:0] RC_NOT_AUTH     = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_EXEC,
        ST_RESP
    } state_t;

    state_t state;

    // card table
    logic [15:0]          balance [NUM_CARDS];
    logic [FW-1:0]        fails   [NUM_CARDS];
    logic [NUM_CARDS-1:0] blocked;
    logic [NUM_CARDS-1:0] auth;

    // latched request
    logic [1:0]        op_q;
    logic [CARD_W-1:0] card_q;
    logic [15:0]       pin_q;
    logic [15:0]       amount_q;

    // working copy of the addressed card
    logic [15:0]   lk_balance;
    logic [FW-1:0] lk_fails;
    logic          lk_blocked;
    logic          lk_auth;

    // evaluated entry and response
    logic [15:0]   ex_balance;
    logic [FW-1:0] ex_fails;
    logic [FW-1:0] fails_inc;
    logic          ex_blocked;
    logic          ex_auth;
    logic [2:0]    ex_code;
    logic [15:0]   ex_resp_bal;

    assign card_blocked = blocked;

    always_comb begin
        ex_balance  = lk_balance;
        ex_fails    = lk_fails;
        ex_blocked  = lk_blocked;
        ex_auth     = lk_auth;
        ex_code     = RC_OK;
        ex_resp_bal = 16'd0;
        fails_inc   = (lk_fails >= MAX_F) ? MAX_F : lk_fails + FW'(1);

        if (lk_blocked && (op_q != OP_UNBLOCK)) begin
            ex_code = RC_BLOCKED;
        end else begin
            case (op_q)
                OP_VERIFY: begin
                    if (pin_q == PIN_VALID) begin
                        ex_fails = '0;
                        ex_auth  = 1'b1;
                        ex_code  = RC_OK;
                    end else begin
                        ex_fails = fails_inc;
                        ex_auth  = 1'b0;
                        if (fails_inc >= MAX_F) begin
                            ex_blocked = 1'b1;
                            ex_code    = RC_BLOCKED;
                        end else begin
                            ex_code = RC_BAD_PIN;
                        end
                    end
                end
                OP_WITHDRAW: begin
                    if (!lk_auth) begin
                        ex_code = RC_NOT_AUTH;
                    end else begin
                        // one withdrawal per successful verify, funded or not
                        ex_auth = 1'b0;
                        if (amount_q <= lk_balance) begin
                            ex_balance = lk_balance - amount_q;
                            ex_code    = RC_OK;
                        end else begin
                            ex_code = RC_INSUFFICIENT;
                        end
                    end
                end
                OP_BALANCE: begin
                    ex_code = lk_auth ? RC_OK : RC_NOT_AUTH;
                end
                default: begin
                    if (pin_q == ADMIN_PIN) begin
                        ex_blocked = 1'b0;
                        ex_fails   = '0;
                        ex_auth    = 1'b0;
                        ex_code    = RC_OK;
                    end else begin
                        ex_code = RC_BAD_PIN;
                    end
                end
            endcase
        end

        if (ex_code == RC_OK)
            ex_resp_bal = ex_balance;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= ST_IDLE;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_code    <= RC_OK;
            resp_balance <= 16'd0;
            op_q         <= OP_VERIFY;
            card_q       <= '0;
            pin_q        <= 16'd0;
            amount_q     <= 16'd0;
            lk_balance   <= 16'd0;
            lk_fails     <= '0;
            lk_blocked   <= 1'b0;
            lk_auth      <= 1'b0;
            blocked      <= '0;
            auth         <= '0;
            for (int i = 0; i < NUM_CARDS; i++) begin
                balance[i] <= BALANCE_INIT;
                fails[i]   <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        op_q      <= req_op;
                        card_q    <= card_id;
                        pin_q     <= pin;
                        amount_q  <= amount;
                        req_ready <= 1'b0;
                        state     <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    lk_balance <= balance[card_q];
                    lk_fails   <= fails[card_q];
                    lk_blocked <= blocked[card_q];
                    lk_auth    <= auth[card_q];
                    state      <= ST_EXEC;
                end
                ST_EXEC: begin
                    balance[card_q] <= ex_balance;
                    fails[card_q]   <= ex_fails;
                    blocked[card_q] <= ex_blocked;
                    auth[card_q]    <= ex_auth;
                    resp_code       <= ex_code;
                    resp_balance    <= ex_resp_bal;
                    state           <= ST_RESP;
                end
                default: begin
                    // card_blocked is already visible one cycle before resp_valid
                    if (!resp_valid) begin
                        resp_valid <= 1'b1;
                    end else if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_atm_bank_responder.sv
// tb_atm_bank_responder
// Directed bench for atm_bank_responder: walks the customer flows (verify,
// withdraw, balance, block/unblock), a stalled response and a reset in the
// middle of a transaction, comparing against hand-computed results.

module tb_atm_bank_responder;

    localparam logic [1:0] OP_VERIFY   = 2'd0;
    localparam logic [1:0] OP_WITHDRAW = 2'd1;
    localparam logic [1:0] OP_BALANCE  = 2'd2;
    localparam logic [1:0] OP_UNBLOCK  = 2'd3;

    localparam logic [2:0] RC_OK           = 3'd0;
    localparam logic [2:0] RC_BAD_PIN      = 3'd1;
    localparam logic [2:0] RC_BLOCKED      = 3'd2;
    localparam logic [2:0] RC_INSUFFICIENT = 3'd3;
    localparam logic [2:0] RC_NOT_AUTH     = 3'd4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [1:0]  card_id = 2'd0;
    logic [15:0] pin = 16'd0;
    logic [15:0] amount = 16'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [2:0]  resp_code;
    logic [15:0] resp_balance;
    logic [3:0]  card_blocked;

    int n_err = 0;
    int n_chk = 0;

    always #5 clock = ~clock;

    atm_bank_responder dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .card_id      (card_id),
        .pin          (pin),
        .amount       (amount),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_code    (resp_code),
        .resp_balance (resp_balance),
        .card_blocked (card_blocked)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Presents one request, scrambles the request inputs after acceptance,
    // checks latency/code/balance and lets the response be consumed.
    task automatic send(input string tag, input logic [1:0] op, input logic [1:0] cid,
                        input logic [15:0] p, input logic [15:0] amt,
                        input logic [2:0] exp_code, input logic [15:0] exp_bal);
        int n;
        req_valid = 1'b1;
        req_op    = op;
        card_id   = cid;
        pin       = p;
        amount    = amt;
        n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        tick();
        req_valid = 1'b0;
        pin       = 16'($urandom);
        amount    = 16'($urandom);
        req_op    = 2'($urandom);
        n = 0;
        while (!resp_valid && n < 10) begin
            tick();
            n++;
        end
        check({tag, " latency"}, n, 3);
        check({tag, " code"}, resp_code, exp_code);
        check({tag, " balance"}, resp_balance, exp_bal);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0;
        tick();
        tick();
        check("rst req_ready", req_ready, 1);
        check("rst resp_valid", resp_valid, 0);
        check("rst resp_code", resp_code, 0);
        check("rst resp_balance", resp_balance, 0);
        check("rst card_blocked", card_blocked, 0);
        reset = 1'b1;
        tick();

        // card 0: verify, withdraw, withdraw again without auth
        send("c0 verify",    OP_VERIFY,   2'd0, 16'd1234, 16'd0,    RC_OK,       16'd10000);
        send("c0 withdraw",  OP_WITHDRAW, 2'd0, 16'd0,    16'd2500, RC_OK,       16'd7500);
        send("c0 withdraw2", OP_WITHDRAW, 2'd0, 16'd0,    16'd100,  RC_NOT_AUTH, 16'd0);

        // card 1: two wrong PINs block it, admin unblock restores it
        send("c1 bad1",      OP_VERIFY,   2'd1, 16'd1111, 16'd0, RC_BAD_PIN, 16'd0);
        check("c1 not yet blocked", card_blocked, 4'b0000);
        send("c1 bad2",      OP_VERIFY,   2'd1, 16'd1111, 16'd0, RC_BLOCKED, 16'd0);
        check("c1 blocked", card_blocked, 4'b0010);
        send("c1 good blk",  OP_VERIFY,   2'd1, 16'd1234, 16'd0, RC_BLOCKED, 16'd0);
        send("c1 bad admin", OP_UNBLOCK,  2'd1, 16'h1234, 16'd0, RC_BAD_PIN, 16'd0);
        check("c1 still blocked", card_blocked, 4'b0010);
        send("c1 unblock",   OP_UNBLOCK,  2'd1, 16'hBEEF, 16'd0, RC_OK,      16'd10000);
        check("c1 unblocked", card_blocked, 4'b0000);
        send("c1 verify",    OP_VERIFY,   2'd1, 16'd1234, 16'd0, RC_OK,      16'd10000);

        // card 2: insufficient funds, auth consumed, exact drain to zero
        send("c2 verify",    OP_VERIFY,   2'd2, 16'd1234, 16'd0,     RC_OK,           16'd10000);
        send("c2 over",      OP_WITHDRAW, 2'd2, 16'd0,    16'd10001, RC_INSUFFICIENT, 16'd0);
        send("c2 balance",   OP_BALANCE,  2'd2, 16'd0,    16'd0,     RC_NOT_AUTH,     16'd0);
        send("c2 verify2",   OP_VERIFY,   2'd2, 16'd1234, 16'd0,     RC_OK,           16'd10000);
        send("c2 bal auth",  OP_BALANCE,  2'd2, 16'd0,    16'd0,     RC_OK,           16'd10000);
        send("c2 drain",     OP_WITHDRAW, 2'd2, 16'd0,    16'd10000, RC_OK,           16'd0);
        send("c2 verify3",   OP_VERIFY,   2'd2, 16'd1234, 16'd0,     RC_OK,           16'd0);
        send("c2 zero amt",  OP_WITHDRAW, 2'd2, 16'd0,    16'd0,     RC_OK,           16'd0);

        // stalled response: verify card 0, then initiator tries a new request
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_op     = OP_VERIFY;
        card_id    = 2'd0;
        pin        = 16'd1234;
        amount     = 16'd0;
        tick();
        req_op  = OP_WITHDRAW;
        card_id = 2'd1;
        pin     = 16'd0;
        amount  = 16'd5000;
        n = 0;
        while (!resp_valid && n < 10) begin
            tick();
            n++;
        end
        check("stall latency", n, 3);
        for (int i = 0; i < 5; i++) begin
            check("stall resp_valid", resp_valid, 1);
            check("stall resp_code", resp_code, RC_OK);
            check("stall resp_balance", resp_balance, 16'd7500);
            check("stall req_ready", req_ready, 0);
            tick();
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        tick();
        check("stall released", resp_valid, 0);
        // card 0 is authorised by the stalled verify; card 1 saw no withdraw
        send("c0 post stall", OP_WITHDRAW, 2'd0, 16'd0, 16'd100, RC_OK,       16'd7400);
        send("c1 untouched",  OP_BALANCE,  2'd1, 16'd0, 16'd0,   RC_OK,       16'd10000);

        // card 3: good PIN clears the fail count
        send("c3 bad1",  OP_VERIFY, 2'd3, 16'd0,    16'd0, RC_BAD_PIN, 16'd0);
        send("c3 good",  OP_VERIFY, 2'd3, 16'd1234, 16'd0, RC_OK,      16'd10000);
        send("c3 bad2",  OP_VERIFY, 2'd3, 16'd0,    16'd0, RC_BAD_PIN, 16'd0);
        check("c3 not blocked", card_blocked, 4'b0000);
        send("c3 bad3",  OP_VERIFY, 2'd3, 16'd0,    16'd0, RC_BLOCKED, 16'd0);
        check("c3 blocked", card_blocked, 4'b1000);

        // reset during LOOKUP of a card 0 withdraw
        send("c0 verify pre", OP_VERIFY, 2'd0, 16'd1234, 16'd0, RC_OK, 16'd7400);
        req_valid = 1'b1;
        req_op    = OP_WITHDRAW;
        card_id   = 2'd0;
        amount    = 16'd400;
        tick();
        req_valid = 1'b0;
        check("accepted before reset", req_ready, 0);
        reset = 1'b0;
        tick();
        check("midrst req_ready", req_ready, 1);
        check("midrst resp_valid", resp_valid, 0);
        check("midrst resp_code", resp_code, 0);
        check("midrst resp_balance", resp_balance, 0);
        check("midrst card_blocked", card_blocked, 0);
        reset = 1'b1;
        tick();
        send("c0 after rst", OP_VERIFY,  2'd0, 16'd1234, 16'd0, RC_OK,       16'd10000);
        send("c3 after rst", OP_BALANCE, 2'd3, 16'd0,    16'd0, RC_NOT_AUTH, 16'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
